// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory-side and decode-side signals.
// The fetch unit takes the master side; the memory model and decode take the slave side.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_fault
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads the instruction port of the
// memory combinationally and queues fetched words in a small FIFO for decode.
// A misaligned fetch PC produces a single fault entry and halts fetch until the
// pipeline redirects it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [31:0]      r_fetchPc;
    logic [31:0]      w_nextPc;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_nextCount;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;

    logic [31:0]      r_pcMem    [DEPTH];
    logic [31:0]      r_instrMem [DEPTH];
    logic             r_faultMem [DEPTH];

    logic             w_valid;
    logic             w_aligned;
    logic             w_pop;
    logic             w_slot;
    logic             w_push;

    // Memory address is the fetch PC itself; decode sees the registered head entry only.
    assign bus.imem_addr = r_fetchPc;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = r_pcMem[r_rdPtr];
    assign bus.out_instr = r_instrMem[r_rdPtr];
    assign bus.out_fault = r_faultMem[r_rdPtr];

    // Handshake and push qualification; a pop frees a slot in the same cycle even when full.
    always_comb begin
        w_valid   = (r_count != '0);
        w_aligned = (r_fetchPc[1:0] == 2'b00);
        w_pop     = w_valid & bus.out_ready;
        w_slot    = (r_count < DEPTH_CNT) | w_pop;
        w_push    = (r_state == RUN) & w_slot & ~bus.redirect;
    end

    // Next FSM state and fetch PC; redirect overrides everything, a misaligned push halts.
    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_fetchPc;
        if (bus.redirect) begin
            w_nextState = RUN;
            w_nextPc    = bus.redirect_pc;
        end else if (w_push) begin
            if (w_aligned) begin
                w_nextPc = r_fetchPc + 32'd4;
            end else begin
                w_nextState = HALT;
            end
        end
    end

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_nextCount = r_count;
        if (bus.redirect) begin
            w_nextCount = '0;
        end else if (w_push && !w_pop) begin
            w_nextCount = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_nextCount = r_count - CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fetch PC and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetchPc <= RESET_PC;
            r_count   <= '0;
        end else begin
            r_fetchPc <= w_nextPc;
            r_count   <= w_nextCount;
        end
    end

    // Read/write pointers; a redirect drops every entry by rewinding both to slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else if (bus.redirect) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
        end
    end

    // Entry storage; a misaligned fetch stores a zero word flagged as a fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pcMem[i]    <= '0;
                r_instrMem[i] <= '0;
                r_faultMem[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_pcMem[r_wrPtr]    <= r_fetchPc;
            r_instrMem[r_wrPtr] <= w_aligned ? bus.imem_rdata : 32'h0;
            r_faultMem[r_wrPtr] <= ~w_aligned;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with DEPTH=2 and RESET_PC=0.
// Memory model: fixed words at 0x0/0x4/0x8, otherwise address XOR 0xDEAD0000.
module tb_fetch_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_unit_if bus_if ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational instruction memory.
    always_comb begin
        case (bus_if.imem_addr)
            32'h0000_0000: bus_if.imem_rdata = 32'h0000_0013;
            32'h0000_0004: bus_if.imem_rdata = 32'h0010_0093;
            32'h0000_0008: bus_if.imem_rdata = 32'h0020_0113;
            default:       bus_if.imem_rdata = bus_if.imem_addr ^ 32'hDEAD_0000;
        endcase
    end

    // Advance one rising edge and land on the following falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Synchronous-looking reset pulse applied on falling edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n                = 1'b0;
        bus_if.redirect      = 1'b0;
        bus_if.redirect_pc   = 32'h0;
        bus_if.out_ready     = 1'b0;
        @(negedge clk);
        tick();
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid got %0b want 0", bus_if.out_valid);
        end
        checks++;
        if (bus_if.out_pc !== 32'h0 || bus_if.out_instr !== 32'h0 || bus_if.out_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_head got pc=%h instr=%h fault=%0b want 0/0/0",
                     bus_if.out_pc, bus_if.out_instr, bus_if.out_fault);
        end
        checks++;
        if (bus_if.imem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_addr got %h want 00000000", bus_if.imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] expPc    [3];
        logic [31:0] expInstr [3];
        expPc[0] = 32'h0; expInstr[0] = 32'h0000_0013;
        expPc[1] = 32'h4; expInstr[1] = 32'h0010_0093;
        expPc[2] = 32'h8; expInstr[2] = 32'h0020_0113;
        rst_n            = 1'b1;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.out_pc !== expPc[i] || bus_if.out_instr !== expInstr[i]) begin
                errors++;
                $display("[TB] FAIL seq_%0d got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         i, bus_if.out_valid, bus_if.out_pc, bus_if.out_instr, expPc[i], expInstr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] expPc    [4];
        logic [31:0] expInstr [4];
        expPc[0] = 32'h0; expInstr[0] = 32'h0000_0013;
        expPc[1] = 32'h4; expInstr[1] = 32'h0010_0093;
        expPc[2] = 32'h8; expInstr[2] = 32'h0020_0113;
        expPc[3] = 32'hC; expInstr[3] = 32'hDEAD_000C;
        bus_if.out_ready = 1'b0;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checks++;
        if (bus_if.imem_addr !== 32'h8) begin
            errors++;
            $display("[TB] FAIL bp_hold_addr got %h want 00000008", bus_if.imem_addr);
        end
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.out_pc !== expPc[i] || bus_if.out_instr !== expInstr[i]) begin
                errors++;
                $display("[TB] FAIL bp_drain_%0d got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         i, bus_if.out_valid, bus_if.out_pc, bus_if.out_instr, expPc[i], expInstr[i]);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        bus_if.out_ready = 1'b0;
        pulse_reset();
        tick();
        tick();
        bus_if.out_ready = 1'b1;
        tick();
        checks++;
        if (bus_if.out_pc !== 32'h4 || bus_if.imem_addr !== 32'hC) begin
            errors++;
            $display("[TB] FAIL redir_setup got head=%h addr=%h want 00000004/0000000c",
                     bus_if.out_pc, bus_if.imem_addr);
        end
        bus_if.out_ready   = 1'b0;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h100;
        tick();
        bus_if.redirect    = 1'b0;
        bus_if.out_ready   = 1'b1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.imem_addr !== 32'h100) begin
            errors++;
            $display("[TB] FAIL redir_bubble got v=%0b addr=%h want v=0 addr=00000100",
                     bus_if.out_valid, bus_if.imem_addr);
        end
        tick();
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_pc !== 32'h100 || bus_if.out_instr !== 32'hDEAD_0100) begin
            errors++;
            $display("[TB] FAIL redir_target got v=%0b pc=%h instr=%h want v=1 pc=00000100 instr=dead0100",
                     bus_if.out_valid, bus_if.out_pc, bus_if.out_instr);
        end
        tick();
        checks++;
        if (bus_if.out_pc !== 32'h104 || bus_if.out_instr !== 32'hDEAD_0104) begin
            errors++;
            $display("[TB] FAIL redir_next got pc=%h instr=%h want 00000104/dead0104",
                     bus_if.out_pc, bus_if.out_instr);
        end
    endtask

    task automatic test_fault();
        bus_if.out_ready   = 1'b0;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h102;
        tick();
        bus_if.redirect    = 1'b0;
        tick();
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_fault !== 1'b1 ||
            bus_if.out_pc !== 32'h102 || bus_if.out_instr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL fault_entry got v=%0b f=%0b pc=%h instr=%h want 1/1/00000102/00000000",
                     bus_if.out_valid, bus_if.out_fault, bus_if.out_pc, bus_if.out_instr);
        end
        tick();
        checks++;
        if (bus_if.imem_addr !== 32'h102 || bus_if.out_pc !== 32'h102) begin
            errors++;
            $display("[TB] FAIL fault_halt_hold got addr=%h head=%h want 00000102/00000102",
                     bus_if.imem_addr, bus_if.out_pc);
        end
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.imem_addr !== 32'h102) begin
            errors++;
            $display("[TB] FAIL fault_after_pop got v=%0b addr=%h want v=0 addr=00000102",
                     bus_if.out_valid, bus_if.imem_addr);
        end
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h200;
        tick();
        bus_if.redirect    = 1'b0;
        tick();
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_fault !== 1'b0 ||
            bus_if.out_pc !== 32'h200 || bus_if.out_instr !== 32'hDEAD_0200) begin
            errors++;
            $display("[TB] FAIL fault_resume got v=%0b f=%0b pc=%h instr=%h want 1/0/00000200/dead0200",
                     bus_if.out_valid, bus_if.out_fault, bus_if.out_pc, bus_if.out_instr);
        end
    endtask

    task automatic test_wrap();
        bus_if.out_ready   = 1'b1;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus_if.redirect    = 1'b0;
        tick();
        checks++;
        if (bus_if.out_pc !== 32'hFFFF_FFFC || bus_if.out_instr !== 32'h2152_FFFC || bus_if.imem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_top got pc=%h instr=%h addr=%h want fffffffc/2152fffc/00000000",
                     bus_if.out_pc, bus_if.out_instr, bus_if.imem_addr);
        end
        tick();
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_pc !== 32'h0 || bus_if.out_instr !== 32'h0000_0013) begin
            errors++;
            $display("[TB] FAIL wrap_zero got v=%0b pc=%h instr=%h want 1/00000000/00000013",
                     bus_if.out_valid, bus_if.out_pc, bus_if.out_instr);
        end
    endtask

    task automatic test_async_reset();
        bus_if.out_ready   = 1'b0;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h302;
        tick();
        bus_if.redirect    = 1'b0;
        tick();
        tick();
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_fault !== 1'b1 || bus_if.imem_addr !== 32'h302) begin
            errors++;
            $display("[TB] FAIL async_setup got v=%0b f=%0b addr=%h want 1/1/00000302",
                     bus_if.out_valid, bus_if.out_fault, bus_if.imem_addr);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.out_fault !== 1'b0 || bus_if.out_pc !== 32'h0 ||
            bus_if.out_instr !== 32'h0 || bus_if.imem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset got v=%0b f=%0b pc=%h instr=%h addr=%h want all zero",
                     bus_if.out_valid, bus_if.out_fault, bus_if.out_pc, bus_if.out_instr, bus_if.imem_addr);
        end
        @(negedge clk);
        rst_n            = 1'b1;
        bus_if.out_ready = 1'b1;
        tick();
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_pc !== 32'h0 || bus_if.out_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_restart got v=%0b pc=%h f=%0b want 1/00000000/0",
                     bus_if.out_valid, bus_if.out_pc, bus_if.out_fault);
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_fault();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
